rgb_fade_scheduler: RTL

- Sequences the RGB status LED from temperature samples (sign + 8-bit magnitude) on a valid/ready handshake.
- Maps each sample to a colour band and a target duty.
- On a colour change, fades the LED fully out, swaps the channel mask, then fades in. Same-colour updates ramp directly to the new duty.
- Contains its own free-running PWM counter. Duty changes are applied only at PWM period boundaries so the LED never glitches.

---
 rtl/rgb_fade_scheduler_if.sv | 11 +
 rtl/rgb_fade_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rgb_fade_scheduler_if.sv
// Temperature sample handshake between a sensor front-end (master) and the
// RGB fade scheduler (slave).
interface rgb_fade_scheduler_if;
  logic       temp_valid;
  logic       temp_sign;
  logic [7:0] temp_mag;
  logic       temp_ready;

  modport master (output temp_valid, output temp_sign, output temp_mag, input temp_ready);
  modport slave  (input temp_valid, input temp_sign, input temp_mag, output temp_ready);
endinterface

// File: rtl/rgb_fade_scheduler.sv
// RGB status LED sequencer: maps temperature samples to a colour band and duty,
// fades out/in across colour changes, drives glitch-free PWM.
module rgb_fade_scheduler #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 50000,
  parameter int DUTY_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  rgb_fade_scheduler_if.slave   temp_if,
  output logic                  R,
  output logic                  G,
  output logic                  B,
  output logic                  busy,
  output logic [PWM_BITS-1:0]   cur_duty
);
  localparam int SCW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int TW  = 10 + DUTY_SHIFT;
  localparam int CW  = (TW > PWM_BITS) ? TW : PWM_BITS;
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [SCW-1:0]      STEP_LAST = SCW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FADE_OUT = 3'd1,
    S_SWITCH   = 3'd2,
    S_FADE_IN  = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [PWM_BITS-1:0] cur_n, tgt_duty, tgt_n, act_duty, ramp;
  logic [2:0]          mask, mask_n, new_mask, new_mask_n;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SCW-1:0]      step_cnt;
  logic                tick, accept;

  // ---------------- band map ----------------
  logic [2:0]          band_mask;
  logic [7:0]          band_base;
  logic [TW-1:0]       tgt_raw;
  logic [PWM_BITS-1:0] band_tgt;

  always_comb begin
    band_mask = 3'b011;
    band_base = 8'd0;
    if (temp_if.temp_sign && temp_if.temp_mag != 8'd0) begin
      if (temp_if.temp_mag < 8'd20) begin
        band_mask = 3'b001; band_base = 8'd0;
      end else begin
        band_mask = 3'b111; band_base = 8'd20;
      end
    end else if (temp_if.temp_mag < 8'd20) begin
      band_mask = 3'b011; band_base = 8'd0;
    end else if (temp_if.temp_mag < 8'd40) begin
      band_mask = 3'b110; band_base = 8'd20;
    end else if (temp_if.temp_mag < 8'd60) begin
      band_mask = 3'b010; band_base = 8'd40;
    end else if (temp_if.temp_mag < 8'd80) begin
      band_mask = 3'b101; band_base = 8'd60;
    end else begin
      band_mask = 3'b100; band_base = 8'd80;
    end
  end

  // Wide enough that (255+2) << DUTY_SHIFT never wraps before saturation.
  assign tgt_raw  = (TW'(temp_if.temp_mag - band_base) + TW'(2)) << DUTY_SHIFT;
  assign band_tgt = (CW'(tgt_raw) > CW'(DUTY_MAX)) ? DUTY_MAX : PWM_BITS'(tgt_raw);

  // ---------------- step tick ----------------
  assign tick = (step_cnt == STEP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    step_cnt <= '0;
    else if (tick) step_cnt <= '0;
    else           step_cnt <= step_cnt + SCW'(1);
  end

  // ---------------- handshake / status ----------------
  assign temp_if.temp_ready = (state == S_IDLE) || (state == S_HOLD) || (state == S_FADE_IN);
  assign accept             = temp_if.temp_valid && temp_if.temp_ready;
  assign busy               = !((state == S_IDLE) || (state == S_HOLD));

  assign ramp = (cur_duty < tgt_duty) ? cur_duty + PWM_BITS'(1) :
                (cur_duty > tgt_duty) ? cur_duty - PWM_BITS'(1) : cur_duty;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cur_duty <= '0;
      tgt_duty <= '0;
      mask     <= 3'b000;
      new_mask <= 3'b000;
    end else begin
      state    <= state_n;
      cur_duty <= cur_n;
      tgt_duty <= tgt_n;
      mask     <= mask_n;
      new_mask <= new_mask_n;
    end
  end

  // An accept always wins over a coincident tick: the ramp simply waits one step.
  always_comb begin
    state_n    = state;
    cur_n      = cur_duty;
    tgt_n      = tgt_duty;
    mask_n     = mask;
    new_mask_n = new_mask;
    case (state)
      S_IDLE, S_HOLD, S_FADE_IN: begin
        if (accept) begin
          new_mask_n = band_mask;
          tgt_n      = band_tgt;
          if (band_mask == mask || mask == 3'b000) begin
            mask_n  = band_mask;
            state_n = S_FADE_IN;
          end else begin
            state_n = S_FADE_OUT;
          end
        end else if (state == S_FADE_IN) begin
          if (tick) cur_n = ramp;
          if (cur_n == tgt_duty) state_n = S_HOLD;
        end
      end
      S_FADE_OUT: begin
        // Wait for the zero to actually reach the PWM before swapping colours.
        if (cur_duty == '0 && act_duty == '0) state_n = S_SWITCH;
        else if (tick && cur_duty != '0)      cur_n   = cur_duty - PWM_BITS'(1);
      end
      S_SWITCH: begin
        mask_n  = new_mask;
        state_n = S_FADE_IN;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------- PWM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt   <= '0;
      act_duty  <= '0;
      {R, G, B} <= 3'b000;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == DUTY_MAX) act_duty <= cur_duty;
      {R, G, B} <= mask & {3{pwm_cnt < act_duty}};
    end
  end
endmodule
